univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised multi-mode register: the successor to the single-bit D flip-flop, generalised to a WIDTH-bit word with hold, parallel load, shift, rotate and clear modes. It keeps the complementary q/q_bar outputs and adds serial I/O plus a shift counter with a done flag, so that serialisers and deserialisers can be assembled directly on top of it. It sits in the datapath as a general-purpose storage/serialisation element driven by a local controller.

## Interface
- WIDTH, 8, word width in bits; legal range 2..64.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 means every register holds.
- mode  input  3  operation select (see Operation).
- data  input  WIDTH  parallel load value.
- ser_in  input  1  serial input bit for shift modes.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  bitwise complement of q; always equal to ~q.
- so_msb  output  1  q[WIDTH-1]; combinational from q.
- so_lsb  output  1  q[0]; combinational from q.
- count  output  $clog2(WIDTH+1)  number of shift/rotate operations since the last load, clear or reset; saturates at WIDTH.
- done  output  1  high while count == WIDTH.

## Operation
- Reset values: q=0, q_bar=all ones, count=0, done=0, so_msb=0, so_lsb=0.
- Priority: rst > en. When rst=1, reset values are applied at the clock edge regardless of en, mode or data.
- When en=0, q, count and done hold.
- Modes, applied when en=1:
  - 000 HOLD: no change.
  - 001 LOAD: q<=data, count<=0.
  - 010 SHL: q<={q[WIDTH-2:0],ser_in}, count++.
  - 011 SHR: q<={ser_in,q[WIDTH-1:1]}, count++.
  - 100 ROTL: q<={q[WIDTH-2:0],q[WIDTH-1]}, count++.
  - 101 ROTR: q<={q[0],q[WIDTH-1:1]}, count++.
  - 110 CLEAR: q<=0, count<=0.
  - 111 reserved: behaves as HOLD; must not alter any state.
- count saturates at WIDTH: a further shift while count==WIDTH still moves q, but count stays at WIDTH.
- done is registered and is exactly (count==WIDTH), so it changes on the same edge as count.
- LOAD and CLEAR both deassert done on the next edge.
- q_bar is produced as the complement of the q register, never as a separate flop, so q and q_bar can never disagree.

## Timing
- All state updates occur on the rising edge of clk. Latency is 1 cycle from inputs sampled at an edge to q/count/done after that edge.
- so_msb and so_lsb reflect the pre-edge q. The bit shifted out by SHL is therefore so_msb sampled before the edge; for SHR it is so_lsb.
- Reset mid-operation (during a shift sequence) clears q and count on that edge. The next cycle resumes normally with whatever mode is presented.
- No combinational path from any input to any output. All outputs are derived from flops only.
- A mode change takes effect on the very next edge; there is no settling cycle.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst=1 for 2 edges with en=1, mode=001, data=8'hFF. Required: q=8'h00, q_bar=8'hFF, count=0, done=0.
- Load then SHL: load 8'hA5, then apply 8 SHL edges with ser_in=1. Required:
  - so_msb sequence before each edge is 1,0,1,0,0,1,0,1.
  - Final q=8'hFF, count=8, done=1 on the 8th edge.
  - A 9th SHL leaves count=8.
- Rotate: load 8'h81, then 1 ROTL gives 8'h03; then 2 ROTR give 8'hC0. Required: count=3, q_bar=8'h3F.
- Enable gating: load 8'h3C, then set en=0 and mode=010 for 5 edges. Required: q=8'h3C and count=0 throughout.
- Reserved mode and CLEAR: q=8'h5A with mode=111 for 3 edges leaves q and count unchanged. Then mode=110 gives q=8'h00, count=0, done=0.
- Reset mid-shift: after 4 SHR edges from 8'hF0, assert rst for 1 edge. Required: q=8'h00 and count=0. Then a LOAD of 8'h12 on the next edge gives q=8'h12.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Multi-mode WIDTH-bit register: hold, parallel load, shift, rotate and clear.
// Adds serial taps and a saturating shift counter with a registered done flag.
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             data,
    input  logic                         ser_in,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             q_bar,
    output logic                         so_msb,
    output logic                         so_lsb,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic [CW-1:0]    count_inc;

    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        if (en) begin
            case (mode_e'(mode))
                MODE_LOAD: begin
                    q_d     = data;
                    count_d = '0;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], ser_in};
                    count_d = count_inc;
                end
                MODE_SHR: begin
                    q_d     = {ser_in, q_q[WIDTH-1:1]};
                    count_d = count_inc;
                end
                MODE_ROTL: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    count_d = count_inc;
                end
                MODE_ROTR: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    count_d = count_inc;
                end
                MODE_CLEAR: begin
                    q_d     = '0;
                    count_d = '0;
                end
                default: begin
                    q_d     = q_q;
                    count_d = count_q;
                end
            endcase
        end
        // done tracks the next count so both flags move on the same edge
        done_d = (count_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign q_bar  = ~q_q;
    assign so_msb = q_q[WIDTH-1];
    assign so_lsb = q_q[0];
    assign count  = count_q;
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] data;
    logic       ser_in;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       so_msb;
    logic       so_lsb;
    logic [3:0] count;
    logic       done;

    int tests_run;
    int tests_failed;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .data   (data),
        .ser_in (ser_in),
        .q      (q),
        .q_bar  (q_bar),
        .so_msb (so_msb),
        .so_lsb (so_lsb),
        .count  (count),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 3'b001; data = 8'hFF; ser_in = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({q, q_bar, count, done, so_msb, so_lsb} !== {8'h00, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: q=%h q_bar=%h count=%0d done=%b msb=%b lsb=%b, want 00 ff 0 0 0 0",
                     q, q_bar, count, done, so_msb, so_lsb);
        end
        $display("[TB] reset q=%h q_bar=%h count=%0d done=%b", q, q_bar, count, done);
        rst = 1'b0;
    endtask

    task automatic test_load_shl();
        logic [7:0] exp_q;
        logic [7:0] msb_seq;
        msb_seq = 8'hA5;
        mode = 3'b001; data = 8'hA5;
        tick();
        tests_run++;
        if ({q, count, done} !== {8'hA5, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL load_a5: q=%h count=%0d done=%b, want a5 0 0", q, count, done);
        end
        exp_q = 8'hA5;
        mode = 3'b010; ser_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (so_msb !== msb_seq[7-i]) begin
                tests_failed++;
                $display("FAIL shl_so_msb[%0d]: got %b, want %b", i, so_msb, msb_seq[7-i]);
            end
            tick();
            exp_q = {exp_q[6:0], 1'b1};
            tests_run++;
            if ({q, count, done} !== {exp_q, 4'(i + 1), (i == 7)}) begin
                tests_failed++;
                $display("FAIL shl_step[%0d]: q=%h count=%0d done=%b, want %h %0d %b",
                         i, q, count, done, exp_q, i + 1, (i == 7));
            end
            $display("[TB] shl step %0d q=%h count=%0d done=%b", i, q, count, done);
        end
        tick();
        tests_run++;
        if ({q, count, done} !== {8'hFF, 4'd8, 1'b1}) begin
            tests_failed++;
            $display("FAIL shl_saturate: q=%h count=%0d done=%b, want ff 8 1", q, count, done);
        end
        $display("[TB] shl 9th q=%h count=%0d done=%b", q, count, done);
    endtask

    task automatic test_rotate();
        mode = 3'b001; data = 8'h81;
        tick();
        mode = 3'b100;
        tick();
        tests_run++;
        if ({q, count} !== {8'h03, 4'd1}) begin
            tests_failed++;
            $display("FAIL rotl: q=%h count=%0d, want 03 1", q, count);
        end
        mode = 3'b101;
        tick();
        tests_run++;
        if ({q, count} !== {8'h81, 4'd2}) begin
            tests_failed++;
            $display("FAIL rotr1: q=%h count=%0d, want 81 2", q, count);
        end
        tick();
        tests_run++;
        if ({q, q_bar, count, done} !== {8'hC0, 8'h3F, 4'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL rotr2: q=%h q_bar=%h count=%0d done=%b, want c0 3f 3 0",
                     q, q_bar, count, done);
        end
        $display("[TB] rotate q=%h q_bar=%h count=%0d", q, q_bar, count);
    endtask

    task automatic test_enable();
        mode = 3'b001; data = 8'h3C;
        tick();
        en = 1'b0; mode = 3'b010; ser_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({q, count, done} !== {8'h3C, 4'd0, 1'b0}) begin
                tests_failed++;
                $display("FAIL enable_hold[%0d]: q=%h count=%0d done=%b, want 3c 0 0",
                         i, q, count, done);
            end
            $display("[TB] en=0 edge %0d q=%h count=%0d", i, q, count);
        end
        en = 1'b1;
    endtask

    task automatic test_reserved_clear();
        mode = 3'b001; data = 8'h5A;
        tick();
        mode = 3'b100;
        repeat (8) tick();
        tests_run++;
        if ({q, count, done} !== {8'h5A, 4'd8, 1'b1}) begin
            tests_failed++;
            $display("FAIL rotl8: q=%h count=%0d done=%b, want 5a 8 1", q, count, done);
        end
        mode = 3'b111; data = 8'h00; ser_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({q, count, done} !== {8'h5A, 4'd8, 1'b1}) begin
                tests_failed++;
                $display("FAIL reserved[%0d]: q=%h count=%0d done=%b, want 5a 8 1",
                         i, q, count, done);
            end
            $display("[TB] reserved edge %0d q=%h count=%0d", i, q, count);
        end
        mode = 3'b110;
        tick();
        tests_run++;
        if ({q, q_bar, count, done} !== {8'h00, 8'hFF, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL clear: q=%h q_bar=%h count=%0d done=%b, want 00 ff 0 0",
                     q, q_bar, count, done);
        end
        $display("[TB] clear q=%h count=%0d done=%b", q, count, done);
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] exp_q;
        mode = 3'b001; data = 8'hF0;
        tick();
        mode = 3'b011; ser_in = 1'b0;
        exp_q = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (so_lsb !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL shr_so_lsb[%0d]: got %b, want %b", i, so_lsb, exp_q[0]);
            end
            tick();
            exp_q = {1'b0, exp_q[7:1]};
        end
        tests_run++;
        if ({q, count} !== {8'h0F, 4'd4}) begin
            tests_failed++;
            $display("FAIL shr4: q=%h count=%0d, want 0f 4", q, count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({q, count, done} !== {8'h00, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_reset: q=%h count=%0d done=%b, want 00 0 0", q, count, done);
        end
        mode = 3'b001; data = 8'h12;
        tick();
        tests_run++;
        if ({q, count} !== {8'h12, 4'd0}) begin
            tests_failed++;
            $display("FAIL load_after_reset: q=%h count=%0d, want 12 0", q, count);
        end
        $display("[TB] reset mid-shift then load q=%h count=%0d", q, count);
    endtask

    task automatic test_back_to_back();
        mode = 3'b001; data = 8'h01;
        tick();
        mode = 3'b010; ser_in = 1'b0;
        tick();
        mode = 3'b011; ser_in = 1'b1;
        tick();
        tests_run++;
        if ({q, count, so_msb, so_lsb} !== {8'h81, 4'd2, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_shl_shr: q=%h count=%0d msb=%b lsb=%b, want 81 2 1 1",
                     q, count, so_msb, so_lsb);
        end
        mode = 3'b101;
        tick();
        tests_run++;
        if ({q, count} !== {8'hC0, 4'd3}) begin
            tests_failed++;
            $display("FAIL b2b_rotr: q=%h count=%0d, want c0 3", q, count);
        end
        mode = 3'b001; data = 8'h55;
        tick();
        tests_run++;
        if ({q, q_bar, count} !== {8'h55, 8'hAA, 4'd0}) begin
            tests_failed++;
            $display("FAIL b2b_load: q=%h q_bar=%h count=%0d, want 55 aa 0", q, q_bar, count);
        end
        $display("[TB] back-to-back q=%h count=%0d", q, count);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; en = 1'b0; mode = 3'b000; data = 8'h00; ser_in = 1'b0;
        test_reset();
        test_load_shl();
        test_rotate();
        test_enable();
        test_reserved_clear();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
